sipo_deser: RTL
===============

# sipo_deser

Parametrised serial-in/parallel-out deserialiser; successor to the fixed 4-bit SIPO register. Collects WIDTH serial bits qualified by a valid strobe, in a selectable bit order, into a word. It presents the word on a one-entry valid/ready output register and flags words lost to back-pressure. It sits between a bit-serial front end and any word-wide consumer.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in pdata[WIDTH-1]; 0 = first received bit lands in pdata[0].
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of the partial word and the overflow flag.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on a rising edge only when this is 1.
- pdata  out  WIDTH  assembled word, valid when pvalid=1.
- pvalid  out  1  output word available.
- pready  in  1  consumer accepts pdata on an edge where pvalid=1 and pready=1.
- bit_cnt  out  $clog2(WIDTH)  number of bits held in the partial word (0..WIDTH-1).
- overflow  out  1  sticky: a completed word was dropped.

## Operation
- Reset (rst=0, asynchronous): shift register, bit_cnt, pdata, pvalid and overflow all go to 0 immediately. They stay 0 while rst=0.
- Shift, on an edge with sin_valid=1 and clr=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - bit_cnt increments.
- sin_valid=0: sreg and bit_cnt hold; gaps of any length are allowed.
- Word completion: occurs on an edge with sin_valid=1, clr=0 and bit_cnt=WIDTH-1.
  - bit_cnt wraps to 0.
  - The completed word is the post-shift sreg value.
- Output register has two states: EMPTY (pvalid=0) and FULL (pvalid=1).
  - EMPTY + completion -> FULL; pdata = completed word.
  - FULL + pready=1 + no completion -> EMPTY; pdata holds its last value.
  - FULL + pready=1 + completion -> stays FULL; pdata = new word (back-to-back, no bubble).
  - FULL + pready=0 + completion -> stays FULL; pdata unchanged; new word dropped; overflow <= 1.
  - FULL + pready=0 + no completion -> hold.
- pready is ignored while EMPTY.
- clr=1 sets sreg=0, bit_cnt=0 and overflow=0.
  - An edge with clr=1 and sin_valid=1 discards the bit: clr wins.
  - clr does not touch pdata or pvalid; the output handshake proceeds normally in that cycle.
- overflow is cleared only by clr or rst.
- pdata is not forced to 0 on drain; consumers qualify it with pvalid.

## Timing
- Latency: pvalid rises on the same edge that samples the last bit. pdata is valid from that edge and is visible one cycle after the last bit was presented.
- Sustained throughput: one word per WIDTH cycles with sin_valid held at 1 and pready held at 1. No lost cycles at word boundaries.
- bit_cnt updates on the sampling edge and is registered, with no combinational path from sin.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset assertion is asynchronous. Deassertion is assumed synchronised externally. The first sample can occur on the first rising edge with rst=1.

## Test plan
- WIDTH=4, MSB_FIRST=1; with pready=1, send bits 1,1,0,1 on consecutive cycles -> pdata=4'b1101 and pvalid=1 for exactly one cycle after the 4th edge; bit_cnt sequence 1,2,3,0.
- WIDTH=4, MSB_FIRST=0; same bits 1,1,0,1 -> pdata=4'b1011. Repeat with sin_valid gaps of 0-3 cycles between bits -> identical result.
- WIDTH=8, MSB_FIRST=1; with pready=0, stream 0xA5 then 0x3C -> pdata=0xA5, pvalid=1, overflow=1 after the 16th bit. Then raise pready -> pvalid=0 next cycle. Pulse clr -> overflow=0.
- WIDTH=8, pready=1; stream 0x12, 0x34 and 0x56 back-to-back with pready pulsed on each completion edge -> pvalid stays 1 through the handoffs; the pdata sequence is 0x12, 0x34, 0x56; overflow=0.
- WIDTH=4; send 3 bits, then assert clr together with a sin_valid bit -> bit_cnt=0 and that bit is discarded; the next 4 bits 0,1,1,0 -> pdata=4'b0110.
- WIDTH=4; after 2 bits with pvalid=1, drop rst mid-cycle -> all outputs 0 immediately, with no clock edge needed. Release rst and send 1,0,0,1 -> pdata=4'b1001.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: WIDTH-bit serial-in/parallel-out deserialiser with a
// one-entry valid/ready output register and a sticky overflow flag.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   clr       synchronous clear of partial word and overflow
//   sin       serial data bit, sampled when sin_valid=1
//   sin_valid serial strobe
//   pdata     assembled word, qualified by pvalid
//   pvalid    output word available
//   pready    consumer accepts pdata when pvalid=1
//   bit_cnt   bits held in the partial word
//   overflow  sticky: a completed word was dropped
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       sin,
    input  logic                       sin_valid,
    output logic [WIDTH-1:0]           pdata,
    output logic                       pvalid,
    input  logic                       pready,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             shift;
    logic             done;
    logic [WIDTH-1:0] sreg_sh;

    assign shift   = sin_valid & ~clr;
    assign done    = shift && (cnt_q == LAST);
    assign sreg_sh = MSB_FIRST ? {sreg_q[WIDTH-2:0], sin}
                               : {sin, sreg_q[WIDTH-1:1]};

    // Output register FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (done) state_d = FULL;
            FULL:  if (pready && !done) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output register FSM: outputs
    always_comb begin
        pvalid = (state_q == FULL);
    end

    // Datapath next state. A completion is accepted into pdata when the
    // slot is empty or is being drained on the same edge; otherwise it
    // is dropped and recorded in overflow.
    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        ovf_d   = ovf_q;
        if (clr) begin
            sreg_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (shift) begin
            sreg_d = sreg_sh;
            cnt_d  = done ? '0 : cnt_q + CW'(1);
        end
        if (done) begin
            if (state_q == EMPTY || pready) begin
                pdata_d = sreg_sh;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            pdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pdata    = pdata_q;
    assign bit_cnt  = cnt_q;
    assign overflow = ovf_q;

endmodule
